// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multi-cycle multiply/divide unit.
//   - op code localparams (3-bit op field)
//   - FSM state and op-class enums
//   - op_class(): classifies an op as multiply, divide, move or none
package mdu_pkg;

   localparam logic [2:0] MULT  = 3'd0;
   localparam logic [2:0] MULTU = 3'd1;
   localparam logic [2:0] DIV   = 3'd2;
   localparam logic [2:0] DIVU  = 3'd3;
   localparam logic [2:0] MTHI  = 3'd4;
   localparam logic [2:0] MTLO  = 3'd5;

   typedef enum logic [1:0] {
      CLS_NONE = 2'd0,
      CLS_MUL  = 2'd1,
      CLS_DIV  = 2'd2,
      CLS_MOVE = 2'd3
   } op_class_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } mdu_state_e;

   function automatic op_class_e op_class(input logic [2:0] op);
      case (op)
         MULT, MULTU: return CLS_MUL;
         DIV, DIVU:   return CLS_DIV;
         MTHI, MTLO:  return CLS_MOVE;
         default:     return CLS_NONE;
      endcase
   endfunction

   // Signed variants are MULT and DIV; everything else is treated unsigned.
   function automatic logic op_is_signed(input logic [2:0] op);
      return (op == MULT) || (op == DIV);
   endfunction

endpackage

// File: rtl/mdu_multicycle_if.sv
// mdu_multicycle_if: request/result bundle between the execute stage and
// the multiply/divide unit.
//   start, op, a, b, cancel : issued by the execute stage (master)
//   busy, hi, lo            : driven by the MDU (slave)
interface mdu_multicycle_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cancel;
   logic             busy;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (output start, op, a, b, cancel, input busy, hi, lo);
   modport slave  (input start, op, a, b, cancel, output busy, hi, lo);
endinterface

// File: rtl/mdu_div_signed.sv
// mdu_div_signed: combinational divider, signed or unsigned.
//   a, b      : dividend, divisor
//   is_signed : 1 = two's-complement operands
//   quo, rem  : quotient (truncated toward zero), remainder (sign of a)
// Divide by zero gives quo = all ones, rem = a. Signed most-negative / -1
// gives quo = a, rem = 0.
module mdu_div_signed #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             is_signed,
   output logic [WIDTH-1:0] quo,
   output logic [WIDTH-1:0] rem
);
   logic             a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag, uq, ur;

   // Divide magnitudes unsigned, then restore signs.
   assign a_neg = is_signed & a[WIDTH-1];
   assign b_neg = is_signed & b[WIDTH-1];
   assign a_mag = a_neg ? (~a + 1'b1) : a;
   assign b_mag = b_neg ? (~b + 1'b1) : b;

   always_comb begin
      uq  = '0;
      ur  = '0;
      quo = '0;
      rem = '0;
      if (b == '0) begin
         quo = '1;
         rem = a;
      end else if (is_signed && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1)) begin
         quo = a;
         rem = '0;
      end else begin
         uq  = a_mag / b_mag;
         ur  = a_mag % b_mag;
         quo = (a_neg ^ b_neg) ? (~uq + 1'b1) : uq;
         rem = a_neg ? (~ur + 1'b1) : ur;
      end
   end
endmodule

// File: rtl/mdu_multicycle.sv
// mdu_multicycle: multi-cycle multiply/divide unit with HI/LO registers.
//   clk   : clock, rising edge
//   reset : asynchronous, active-low
//   bus   : mdu_multicycle_if slave (start/op/a/b/cancel in, busy/hi/lo out)
// The full result is computed at the start edge and parked in pending
// registers; a down-counter models the latency and commits it to hi/lo.
module mdu_multicycle
   import mdu_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic            clk,
   input  logic            reset,
   mdu_multicycle_if.slave bus
);
   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);
   localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
   localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);

   mdu_state_e         state_reg;
   logic [CW-1:0]      cnt_reg;
   logic               busy_reg;
   logic [WIDTH-1:0]   hi_reg, lo_reg;
   logic [WIDTH-1:0]   pend_hi_reg, pend_lo_reg;

   op_class_e          cls;
   logic               sgn;
   logic [2*WIDTH-1:0] mul_a, mul_b, prod;
   logic [WIDTH-1:0]   quo, rem;

   assign cls = op_class(bus.op);
   assign sgn = op_is_signed(bus.op);

   // Sign-adjust to 2*WIDTH so the low 2*WIDTH bits of the product are the
   // exact signed or unsigned result.
   assign mul_a = sgn ? {{WIDTH{bus.a[WIDTH-1]}}, bus.a} : {{WIDTH{1'b0}}, bus.a};
   assign mul_b = sgn ? {{WIDTH{bus.b[WIDTH-1]}}, bus.b} : {{WIDTH{1'b0}}, bus.b};
   assign prod  = mul_a * mul_b;

   mdu_div_signed #(.WIDTH(WIDTH)) u_div (
      .a         (bus.a),
      .b         (bus.b),
      .is_signed (sgn),
      .quo       (quo),
      .rem       (rem)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg   <= ST_IDLE;
         cnt_reg     <= '0;
         busy_reg    <= 1'b0;
         hi_reg      <= '0;
         lo_reg      <= '0;
         pend_hi_reg <= '0;
         pend_lo_reg <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               // cancel suppresses any start, including moves
               if (bus.start && !bus.cancel) begin
                  case (cls)
                     CLS_MUL: begin
                        {pend_hi_reg, pend_lo_reg} <= prod;
                        cnt_reg   <= MULT_LOAD;
                        busy_reg  <= 1'b1;
                        state_reg <= ST_BUSY;
                     end
                     CLS_DIV: begin
                        pend_hi_reg <= rem;
                        pend_lo_reg <= quo;
                        cnt_reg     <= DIV_LOAD;
                        busy_reg    <= 1'b1;
                        state_reg   <= ST_BUSY;
                     end
                     CLS_MOVE: begin
                        if (bus.op == MTHI) hi_reg <= bus.a;
                        else                lo_reg <= bus.a;
                     end
                     default: ;
                  endcase
               end
            end
            ST_BUSY: begin
               // cancel wins over the commit; start is ignored while busy
               if (bus.cancel) begin
                  cnt_reg     <= '0;
                  busy_reg    <= 1'b0;
                  pend_hi_reg <= '0;
                  pend_lo_reg <= '0;
                  state_reg   <= ST_IDLE;
               end else if (cnt_reg == CW'(1)) begin
                  hi_reg    <= pend_hi_reg;
                  lo_reg    <= pend_lo_reg;
                  cnt_reg   <= '0;
                  busy_reg  <= 1'b0;
                  state_reg <= ST_IDLE;
               end else begin
                  cnt_reg <= cnt_reg - 1'b1;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign bus.busy = busy_reg;
   assign bus.hi   = hi_reg;
   assign bus.lo   = lo_reg;
endmodule

// File: tb/tb_mdu_multicycle.sv
// tb_mdu_multicycle: scoreboard bench for mdu_multicycle at WIDTH=32,
// MULT_CYCLES=5, DIV_CYCLES=10. Expected {hi,lo} and latency are queued at
// issue and popped when busy falls.
module tb_mdu_multicycle;
   import mdu_pkg::*;

   localparam int W    = 32;
   localparam int MLAT = 5;
   localparam int DLAT = 10;

   typedef struct {
      string       tag;
      logic [63:0] hilo;
      int          lat;
   } exp_t;

   logic clk;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   exp_t sb_q[$];
   logic [31:0] hi_m, lo_m;

   mdu_multicycle_if #(.WIDTH(W)) bus ();

   mdu_multicycle #(.WIDTH(W), .MULT_CYCLES(MLAT), .DIV_CYCLES(DLAT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Independent reference for the random section.
   function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
      longint sa, sb, q, r;
      logic [63:0] ua, ub;
      sa = longint'($signed(av));
      sb = longint'($signed(bv));
      ua = {32'b0, av};
      ub = {32'b0, bv};
      case (o)
         MULT:  return 64'(sa * sb);
         MULTU: return ua * ub;
         DIV: begin
            if (bv == 0) return {av, 32'hFFFF_FFFF};
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
         end
         DIVU: begin
            if (bv == 0) return {av, 32'hFFFF_FFFF};
            return {ua[31:0] % ub[31:0], ua[31:0] / ub[31:0]};
         end
         default: return {hi_m, lo_m};
      endcase
   endfunction

   task automatic issue(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = o;
      bus.a     = av;
      bus.b     = bv;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   // Counts edges until busy falls (bounded); flags any hi/lo change while busy.
   task automatic wait_done(output int n, output logic moved);
      logic [63:0] prev;
      prev  = {bus.hi, bus.lo};
      moved = 1'b0;
      n     = 0;
      while (bus.busy && n < 100) begin
         @(posedge clk);
         #1;
         n++;
         if (bus.busy && ({bus.hi, bus.lo} !== prev)) moved = 1'b1;
      end
   endtask

   task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] av,
                         input logic [31:0] bv, input logic [63:0] exp_hilo, input int lat);
      exp_t e;
      int   n;
      logic moved;
      sb_q.push_back('{tag: tag, hilo: exp_hilo, lat: lat});
      issue(o, av, bv);
      wait_done(n, moved);
      e = sb_q.pop_front();
      chk({e.tag, "_lat"}, 64'(n), 64'(e.lat));
      chk({e.tag, "_hilo"}, {bus.hi, bus.lo}, e.hilo);
      chk({e.tag, "_stable"}, 64'(moved), 64'd0);
      {hi_m, lo_m} = e.hilo;
      $display("op %s a=%h b=%h -> hi=%h lo=%h busy_cycles=%0d", tag, av, bv, bus.hi, bus.lo, n);
   endtask

   initial begin
      int   n;
      logic moved;
      exp_t e;
      logic [2:0]  ro;
      logic [31:0] ra, rb;

      bus.start  = 1'b0;
      bus.op     = 3'd0;
      bus.a      = '0;
      bus.b      = '0;
      bus.cancel = 1'b0;
      reset      = 1'b0;
      hi_m       = '0;
      lo_m       = '0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("reset_busy", 64'(bus.busy), 64'd0);
      chk("reset_hilo", {bus.hi, bus.lo}, 64'd0);
      $display("reset released busy=%b hi=%h lo=%h", bus.busy, bus.hi, bus.lo);

      run_op("mult",  MULT,  32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA, MLAT);
      run_op("multu", MULTU, 32'hFFFF_FFFE, 32'd3, 64'h0000_0002_FFFF_FFFA, MLAT);
      run_op("div",   DIV,   32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, DLAT);
      run_op("divu0", DIVU,  32'h0000_1234, 32'd0, 64'h0000_1234_FFFF_FFFF, DLAT);
      run_op("divov", DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, DLAT);
      run_op("div0s", DIV,   32'hFFFF_FF00, 32'd0, 64'hFFFF_FF00_FFFF_FFFF, DLAT);

      // MTHI: one edge, no busy
      issue(MTHI, 32'hDEAD_BEEF, 32'd0);
      chk("mthi_busy", 64'(bus.busy), 64'd0);
      chk("mthi_hilo", {bus.hi, bus.lo}, {32'hDEAD_BEEF, lo_m});
      hi_m = 32'hDEAD_BEEF;
      $display("op mthi a=deadbeef -> hi=%h lo=%h busy=%b", bus.hi, bus.lo, bus.busy);

      // MULT cancelled on its 3rd busy cycle
      issue(MULT, 32'd7, 32'd9);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("cancel_pre_busy", 64'(bus.busy), 64'd1);
      @(negedge clk);
      bus.cancel = 1'b1;
      @(posedge clk); #1;
      bus.cancel = 1'b0;
      chk("cancel_busy", 64'(bus.busy), 64'd0);
      chk("cancel_hilo", {bus.hi, bus.lo}, {hi_m, lo_m});
      repeat (8) @(posedge clk);
      #1;
      chk("cancel_nocommit", {bus.hi, bus.lo}, {hi_m, lo_m});
      $display("op mult cancelled -> hi=%h lo=%h busy=%b", bus.hi, bus.lo, bus.busy);

      // cancel while idle suppresses a move
      @(negedge clk);
      bus.start = 1'b1; bus.op = MTLO; bus.a = 32'h1111_1111; bus.cancel = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.cancel = 1'b0;
      chk("idle_cancel_hilo", {bus.hi, bus.lo}, {hi_m, lo_m});
      $display("op mtlo with cancel -> hi=%h lo=%h", bus.hi, bus.lo);

      // reserved op code
      issue(3'd6, 32'hAAAA_AAAA, 32'h1);
      chk("reserved_busy", 64'(bus.busy), 64'd0);
      chk("reserved_hilo", {bus.hi, bus.lo}, {hi_m, lo_m});
      $display("op reserved -> hi=%h lo=%h busy=%b", bus.hi, bus.lo, bus.busy);

      // MTLO issued while a DIVU is busy is ignored
      sb_q.push_back('{tag: "divu_busy", hilo: 64'h0000_0002_0000_000E, lat: DLAT});
      issue(DIVU, 32'd100, 32'd7);
      @(posedge clk); #1;
      @(negedge clk);
      bus.start = 1'b1; bus.op = MTLO; bus.a = 32'h55;
      @(posedge clk); #1;
      bus.start = 1'b0;
      chk("busy_mtlo_lo", 64'(bus.lo), 64'(lo_m));
      chk("busy_mtlo_busy", 64'(bus.busy), 64'd1);
      wait_done(n, moved);
      e = sb_q.pop_front();
      chk({e.tag, "_lat"}, 64'(n + 2), 64'(e.lat));
      chk({e.tag, "_hilo"}, {bus.hi, bus.lo}, e.hilo);
      chk({e.tag, "_stable"}, 64'(moved), 64'd0);
      {hi_m, lo_m} = e.hilo;
      $display("op divu with mtlo during busy -> hi=%h lo=%h busy_cycles=%0d", bus.hi, bus.lo, n + 2);

      // random back-to-back ops against the model
      for (int i = 0; i < 10; i++) begin
         ro = 3'($urandom_range(0, 3));
         ra = $urandom;
         rb = (i == 4) ? 32'd0 : ((i == 6) ? 32'($urandom_range(1, 9)) : $urandom);
         if (i == 7) begin
            ra = 32'h8000_0000;
            rb = 32'hFFFF_FFFF;
         end
         run_op($sformatf("rand%0d", i), ro, ra, rb, model(ro, ra, rb),
                (op_class(ro) == CLS_MUL) ? MLAT : DLAT);
      end

      // reset in the middle of a DIV: immediate clear, no commit afterwards
      issue(DIV, 32'd1000, 32'd3);
      repeat (3) @(posedge clk);
      @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      chk("rst_mid_busy", 64'(bus.busy), 64'd0);
      chk("rst_mid_hilo", {bus.hi, bus.lo}, 64'd0);
      @(negedge clk);
      reset = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      chk("rst_nocommit_hilo", {bus.hi, bus.lo}, 64'd0);
      chk("rst_nocommit_busy", 64'(bus.busy), 64'd0);
      $display("reset mid-div -> hi=%h lo=%h busy=%b", bus.hi, bus.lo, bus.busy);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mdu_multicycle.md
# mdu_multicycle

Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers, for the pipelined MIPS core's execute stage. It accepts MULT/MULTU/DIV/DIVU and MTHI/MTLO operations and holds busy for a configurable latency so the hazard logic can stall MFHI/MFLO and further MDU ops. It replaces single-cycle, width-fixed arithmetic with configurable width and latencies, and adds a cancel path for exceptions and flushes.

## Interface
- WIDTH, 32, operand and HI/LO width in bits (≥ 8).
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (≥ 1).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (≥ 1).
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  operation request, sampled on the rising edge.
- op  in  3  operation code from mdu_pkg: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5; 6–7 reserved.
- a  in  WIDTH  rs operand.
- b  in  WIDTH  rt operand.
- cancel  in  1  abort any in-flight operation.
- busy  out  1  operation in flight.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

## Operation
- Reset (asynchronous, active-low): hi=0, lo=0, busy=0, counter=0, pending result cleared.
- Idle (busy=0) with start=1:
  - MULT/MULTU/DIV/DIVU: capture the 2·WIDTH result into pending registers, load the counter with MULT_CYCLES or DIV_CYCLES, set busy.
  - MTHI/MTLO: write a into hi or lo at that edge. busy stays 0.
  - Reserved op codes: no effect.
- start while busy=1: ignored. No queueing. The hazard unit must not issue.
- MULT: signed WIDTH×WIDTH → {hi,lo}. MULTU: same, unsigned.
- DIV: signed. Quotient truncates toward zero into lo. Remainder takes the sign of the dividend, into hi.
- DIVU: unsigned division, same hi/lo placement.
- Divide by zero (b=0): lo = all ones, hi = a. Applies to both signed and unsigned.
- Signed overflow (a = most-negative, b = −1): lo = a, hi = 0.
- Busy state: the counter decrements each edge. On the edge where it reaches 0, pending is committed to {hi,lo} and busy clears.
- cancel=1 while busy: the counter is cleared and busy drops at that edge. hi/lo keep their pre-op values and pending is discarded.
- cancel=1 while idle: start is suppressed, including MTHI/MTLO.
- cancel has priority over both commit and start in the same cycle.

## Timing
- The start edge is edge E. busy is high from E through E+N, where N is the op latency, and low after E+N.
- New hi/lo values are visible after edge E+N, in the same cycle busy falls.
- hi/lo never change while busy=1.
- hi/lo change only on a commit, an MTHI/MTLO, or reset.
- MTHI/MTLO: the new value is visible after edge E. Latency 1, no busy.
- A new start is accepted in the cycle busy is low. Back-to-back ops are separated by exactly N+1 edges.
- Reset asserted mid-operation forces the reset state immediately, with no commit.
- Outputs come directly from registers. There is no combinational path from inputs to outputs.

## Structure
- Package mdu_pkg holds:
  - op code localparams: MULT, MULTU, DIV, DIVU, MTHI, MTLO;
  - a function that classifies an op as multiply, divide or move.
- The counter width is $clog2(max(MULT_CYCLES, DIV_CYCLES)+1).
- Sub-module mdu_div_signed: combinational signed/unsigned divider. It carries the divide-by-zero and overflow rules so the top level holds only control and registers.
- Multiplication uses a plain `*` on sign-adjusted 2·WIDTH operands.

## Test plan
- Reset then MULT a=0xFFFFFFFE (−2), b=3 at WIDTH=32 → busy high for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU with the same operands → hi=0x00000002, lo=0xFFFFFFFA after 5 cycles.
- DIV a=−7, b=2 → after 10 busy cycles lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1).
- Corner cases:
  - DIVU a=0x1234, b=0 → lo=0xFFFFFFFF, hi=0x00001234.
  - DIV a=0x80000000, b=−1 → lo=0x80000000, hi=0.
- MTHI a=0xDEADBEEF → hi updates after one edge and busy stays 0. Then start MULT with cancel asserted on its 3rd busy cycle → busy drops and hi stays 0xDEADBEEF.
- start during busy, with op=MTLO a=0x55 → ignored and lo unchanged. Then reset asserted mid-DIV → hi=lo=0 and busy=0 immediately, with no commit after release.
